// File: rtl/iob_debounce_pkg.sv
// rtl/iob_debounce_pkg.sv - shared state encoding and limits for the iob_debounce input conditioner
package iob_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  localparam int GLITCH_CNT_W    = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - generic multi-flop synchronizer chain with clock enable and async reset
module iob_sync #(
  parameter int                DATA_W  = 1,
  parameter int                STAGES  = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] chain_q [STAGES];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
    end else if (cke_i) begin
      chain_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign data_o = chain_q[STAGES-1];

endmodule

// File: rtl/iob_debounce.sv
// rtl/iob_debounce.sv - synchronize and debounce a raw level with a programmable stability count
// Optional glitch counter enabled by defining IOB_DEBOUNCE_GLITCH_CNT_EN.
module iob_debounce
  import iob_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             bit_i,
  input  logic [CNT_W-1:0] threshold_i,
  output logic             bit_o,
  output logic             busy_o
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic                    glitch_clr_i,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
`endif
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("iob_debounce: SYNC_STAGES out of range");
  end

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, thr;
  logic             bit_q, bit_d;

  iob_sync #(
    .DATA_W (1),
    .STAGES (SYNC_STAGES),
    .RST_VAL(RST_VAL)
  ) u_sync (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .cke_i   (cke_i),
    .data_i  (bit_i),
    .data_o  (sync)
  );

  // A threshold of zero behaves like one: accept on the first differing cycle.
  assign thr     = (threshold_i == '0) ? CNT_W'(1) : threshold_i;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      bit_q   <= RST_VAL;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      ST_STABLE: begin
        if (sync == bit_q) begin
          cnt_d = '0;
        end else if (thr == CNT_W'(1)) begin
          bit_d = ~bit_q;
        end else begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (sync == bit_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        // >= so a threshold lowered mid-qualification accepts immediately
        end else if (cnt_inc >= thr) begin
          bit_d   = ~bit_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_CHECK);
  end

  assign bit_o = bit_q;

`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  logic                    glitch_evt;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  assign glitch_evt = (state_q == ST_CHECK) && (sync == bit_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      glitch_cnt_q <= '0;
    end else if (cke_i) begin
      if (glitch_clr_i) begin
        glitch_cnt_q <= '0;
      end else if (glitch_evt && glitch_cnt_q != '1) begin
        glitch_cnt_q <= glitch_cnt_q + GLITCH_CNT_W'(1);
      end
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_iob_debounce.sv
// tb/tb_iob_debounce.sv - directed self-checking bench for iob_debounce
module tb_iob_debounce;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cke = 1'b1;
  logic        bit_in = 1'b0;
  logic [15:0] thr = 16'd4;
  logic        bit_out;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  logic        glitch_clr = 1'b0;
  logic [7:0]  glitch_cnt;
`endif

  always #5 clk = ~clk;

  iob_debounce #(
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .RST_VAL    (1'b0)
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .cke_i      (cke),
    .bit_i      (bit_in),
    .threshold_i(thr),
    .bit_o      (bit_out),
    .busy_o     (busy)
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_clr_i(glitch_clr),
    .glitch_cnt_o(glitch_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bit_in = 1'b1;
    thr    = 16'd4;
    repeat (3) tick();
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit got %b exp 0", bit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    arst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (bit_out !== (e == 6)) begin errors++; $display("FAIL reset_release_bit edge %0d got %b exp %b", e, bit_out, (e == 6)); end
    end
    bit_in = 1'b0;
    repeat (6) tick();
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_return_low got %b exp 0", bit_out); end
  endtask

  task automatic test_clean_edges();
    thr    = 16'd4;
    bit_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (busy !== (e >= 3 && e <= 5)) begin errors++; $display("FAIL rise_busy edge %0d got %b exp %b", e, busy, (e >= 3 && e <= 5)); end
      checks++;
      if (bit_out !== (e == 6)) begin errors++; $display("FAIL rise_bit edge %0d got %b exp %b", e, bit_out, (e == 6)); end
    end
    bit_in = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (busy !== (e >= 3 && e <= 5)) begin errors++; $display("FAIL fall_busy edge %0d got %b exp %b", e, busy, (e >= 3 && e <= 5)); end
      checks++;
      if (bit_out !== (e < 6)) begin errors++; $display("FAIL fall_bit edge %0d got %b exp %b", e, bit_out, (e < 6)); end
    end
  endtask

  task automatic test_glitch();
    thr    = 16'd4;
    bit_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 3) bit_in = 1'b0;
      checks++;
      if (bit_out !== 1'b0) begin errors++; $display("FAIL glitch_bit edge %0d got %b exp 0", e, bit_out); end
      if (e == 5) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid got %b exp 1", busy); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("FAIL glitch_cnt got %0d exp 1", glitch_cnt); end
`endif
  endtask

  task automatic test_threshold_zero_one();
    for (int t = 0; t <= 1; t++) begin
      thr    = 16'(t);
      bit_in = 1'b1;
      for (int e = 1; e <= 6; e++) begin
        tick();
        if (e == 1) bit_in = 1'b0;
        checks++;
        if (bit_out !== (e == 3)) begin errors++; $display("FAIL thr%0d_pulse edge %0d got %b exp %b", t, e, bit_out, (e == 3)); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL thr%0d_busy edge %0d got %b exp 0", t, e, busy); end
      end
    end
  endtask

  task automatic test_cke_gating();
    thr    = 16'd4;
    bit_in = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cke_busy_pre got %b exp 1", busy); end
    cke = 1'b0;
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cke_busy_frozen got %b exp 1", busy); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL cke_bit_frozen got %b exp 0", bit_out); end
    cke = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (bit_out !== (e == 3)) begin errors++; $display("FAIL cke_resume_bit edge %0d got %b exp %b", e, bit_out, (e == 3)); end
    end
    bit_in = 1'b0;
    repeat (6) tick();
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL cke_return_low got %b exp 0", bit_out); end
  endtask

  task automatic test_threshold_lower();
    thr    = 16'd10;
    bit_in = 1'b1;
    repeat (4) tick();
    checks++; if (bit_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL thr_lower_pre got bit %b busy %b exp bit 0 busy 1", bit_out, busy); end
    thr = 16'd2;
    tick();
    checks++; if (bit_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL thr_lower_accept got bit %b busy %b exp bit 1 busy 0", bit_out, busy); end
    thr = 16'd4;
  endtask

  task automatic test_reset_mid_check();
    // Enters with bit_out high; qualify a falling candidate to count 2, then reset.
    thr    = 16'd4;
    bit_in = 1'b0;
    repeat (4) tick();
    checks++; if (bit_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got bit %b busy %b exp bit 1 busy 1", bit_out, busy); end
    #2 arst_n = 1'b0;
    #1;
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL midrst_bit got %b exp 0", bit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL midrst_glitch_cnt got %0d exp 0", glitch_cnt); end
`endif
    bit_in = 1'b1;
    #2 arst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (bit_out !== (e == 6)) begin errors++; $display("FAIL midrst_release_bit edge %0d got %b exp %b", e, bit_out, (e == 6)); end
    end
    bit_in = 1'b0;
    repeat (6) tick();
  endtask

`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  task automatic test_glitch_saturate();
    thr = 16'd2;
    for (int n = 0; n < 300; n++) begin
      bit_in = 1'b1;
      tick();
      bit_in = 1'b0;
      repeat (3) tick();
    end
    checks++; if (glitch_cnt !== 8'hFF) begin errors++; $display("FAIL glitch_sat got %0d exp 255", glitch_cnt); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL glitch_sat_bit got %b exp 0", bit_out); end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL glitch_clr got %0d exp 0", glitch_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_edges();
    test_glitch();
    test_threshold_zero_one();
    test_cke_gating();
    test_threshold_lower();
    test_reset_mid_check();
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
    test_glitch_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
